axi_lite_master: RTL and testbench

AXI4-Lite initiator that converts a simple single-beat request/response port into AXI4-Lite read and write transactions. It is the master-side counterpart of the MMIO subsystem's AXI4-Lite slave port and sits between a processor load/store unit (or a debug/test driver) and the main bus. It allows one transaction in flight at a time, issues AW and W together with independent handshake tracking, and returns a single-cycle response pulse.

---
 rtl/axi_lite_master_if.sv | 39 +++
 rtl/axi_lite_master.sv | 108 ++++++++++
 tb/tb_axi_lite_master.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if: AXI4-Lite channel bundle between an initiator and the bus.
interface axi_lite_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );
    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator behind a simple request/response port.
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    arst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [1:0]              resp_code,
    axi_lite_master_if.master       m_axi
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, DONE} state_t;
    state_t state, state_n;
    logic aw_done, w_done;
    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign req_ready    = state == IDLE;
    assign accept       = req_ready && req_valid;
    assign aw_hs        = m_axi.awvalid && m_axi.awready;
    assign w_hs         = m_axi.wvalid && m_axi.wready;
    assign b_hs         = m_axi.bready && m_axi.bvalid;
    assign ar_hs        = m_axi.arvalid && m_axi.arready;
    assign r_hs         = m_axi.rready && m_axi.rvalid;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (req_write ? WRITE : READ) : IDLE;
            // AW and W may complete in either order; the last one closes the phase
            WRITE:   state_n = ((aw_done || aw_hs) && (w_done || w_hs)) ? WRESP : WRITE;
            WRESP:   state_n = b_hs ? DONE : WRESP;
            READ:    state_n = ar_hs ? RRESP : READ;
            RRESP:   state_n = r_hs ? DONE : RRESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst)
        if (arst) state <= IDLE;
        else      state <= state_n;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            resp_code     <= 2'b00;
        end else begin
            if (accept) begin
                if (req_write) begin
                    m_axi.awaddr <= req_addr;
                    m_axi.wdata  <= req_wdata;
                    m_axi.wstrb  <= req_wstrb;
                end else begin
                    m_axi.araddr <= req_addr;
                end
                m_axi.awvalid <= req_write;
                m_axi.wvalid  <= req_write;
                m_axi.arvalid <= !req_write;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
            end
            if (aw_hs) begin
                m_axi.awvalid <= 1'b0;
                aw_done       <= 1'b1;
            end
            if (w_hs) begin
                m_axi.wvalid <= 1'b0;
                w_done       <= 1'b1;
            end
            if (ar_hs) m_axi.arvalid <= 1'b0;
            m_axi.bready <= state_n == WRESP;
            m_axi.rready <= state_n == RRESP;
            resp_valid   <= state_n == DONE;
            if (b_hs) begin
                resp_rdata <= '0;
                resp_code  <= m_axi.bresp;
                resp_err   <= m_axi.bresp != 2'b00;
            end
            if (r_hs) begin
                resp_rdata <= m_axi.rdata;
                resp_code  <= m_axi.rresp;
                resp_err   <= m_axi.rresp != 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed and randomized-delay checks of the AXI4-Lite initiator.
module tb_axi_lite_master;
    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;

    always #5 aclk = ~aclk;

    axi_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_axi ();

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .resp_code(resp_code), .m_axi(m_axi)
    );

    int n_checks = 0;
    int n_fail = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic        rand_mode = 1'b0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rdata_val = '0;

    int aw_tot = 0, w_tot = 0, b_tot = 0, ar_tot = 0, r_tot = 0, resp_tot = 0, viol = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic [31:0] ar_log [16];

    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_resp = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;

    // Bus monitor: handshake counts, last payloads, and valid/payload stability violations
    always @(posedge aclk) begin
        if (arst) begin
            p_aw   <= 1'b0;
            p_w    <= 1'b0;
            p_ar   <= 1'b0;
            p_resp <= 1'b0;
        end else begin
            viol <= viol
                + ((p_aw && (!m_axi.awvalid || m_axi.awaddr != p_awaddr)) ? 1 : 0)
                + ((p_w && (!m_axi.wvalid || m_axi.wdata != p_wdata || m_axi.wstrb != p_wstrb)) ? 1 : 0)
                + ((p_ar && (!m_axi.arvalid || m_axi.araddr != p_araddr)) ? 1 : 0)
                + ((p_resp && resp_valid) ? 1 : 0);
            p_aw     <= m_axi.awvalid && !m_axi.awready;
            p_w      <= m_axi.wvalid && !m_axi.wready;
            p_ar     <= m_axi.arvalid && !m_axi.arready;
            p_resp   <= resp_valid;
            p_awaddr <= m_axi.awaddr;
            p_wdata  <= m_axi.wdata;
            p_wstrb  <= m_axi.wstrb;
            p_araddr <= m_axi.araddr;
            if (m_axi.awvalid && m_axi.awready) begin
                aw_tot      <= aw_tot + 1;
                last_awaddr <= m_axi.awaddr;
            end
            if (m_axi.wvalid && m_axi.wready) begin
                w_tot      <= w_tot + 1;
                last_wdata <= m_axi.wdata;
                last_wstrb <= m_axi.wstrb;
            end
            if (m_axi.bvalid && m_axi.bready) b_tot <= b_tot + 1;
            if (m_axi.arvalid && m_axi.arready) begin
                ar_tot              <= ar_tot + 1;
                last_araddr         <= m_axi.araddr;
                ar_log[4'(ar_tot)]  <= m_axi.araddr;
            end
            if (m_axi.rvalid && m_axi.rready) r_tot <= r_tot + 1;
            if (resp_valid) resp_tot <= resp_tot + 1;
        end
    end

    // Slave model: ready after a configured number of wait cycles, B/R after the address/data beats
    initial begin
        int awc, wc, bc, arc, rc, awd, wd, bd, ard, rd;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0; awd = 0; wd = 0; bd = 0; ard = 0; rd = 0;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
        m_axi.bvalid = 1'b0; m_axi.rvalid = 1'b0;
        m_axi.bresp = 2'b00; m_axi.rresp = 2'b00; m_axi.rdata = '0;
        forever begin
            @(negedge aclk);
            if (arst) begin
                m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
                m_axi.bvalid = 1'b0; m_axi.rvalid = 1'b0;
                awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
            end else begin
                if (m_axi.awvalid) begin
                    if (awc == 0) awd = rand_mode ? int'($urandom_range(0, 3)) : aw_dly;
                    m_axi.awready = awc >= awd;
                    awc++;
                end else begin
                    m_axi.awready = 1'b0;
                    awc = 0;
                end
                if (m_axi.wvalid) begin
                    if (wc == 0) wd = rand_mode ? int'($urandom_range(0, 3)) : w_dly;
                    m_axi.wready = wc >= wd;
                    wc++;
                end else begin
                    m_axi.wready = 1'b0;
                    wc = 0;
                end
                if (m_axi.arvalid) begin
                    if (arc == 0) ard = rand_mode ? int'($urandom_range(0, 3)) : ar_dly;
                    m_axi.arready = arc >= ard;
                    arc++;
                end else begin
                    m_axi.arready = 1'b0;
                    arc = 0;
                end
                if (aw_tot > b_tot && w_tot > b_tot) begin
                    if (bc == 0) bd = rand_mode ? int'($urandom_range(0, 3)) : b_dly;
                    m_axi.bvalid = bc >= bd;
                    m_axi.bresp  = bresp_val;
                    bc++;
                end else begin
                    m_axi.bvalid = 1'b0;
                    bc = 0;
                end
                if (ar_tot > r_tot) begin
                    if (rc == 0) rd = rand_mode ? int'($urandom_range(0, 3)) : r_dly;
                    m_axi.rvalid = rc >= rd;
                    m_axi.rdata  = rdata_val;
                    m_axi.rresp  = rresp_val;
                    rc++;
                end else begin
                    m_axi.rvalid = 1'b0;
                    rc = 0;
                end
            end
        end
    end

    task automatic wait_ready(output logic ok);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        ok = req_ready;
    endtask

    task automatic wait_resp(output logic ok);
        int t = 0;
        while (!resp_valid && t < 200) begin
            @(negedge aclk);
            t++;
        end
        ok = resp_valid;
    endtask

    task automatic test_reset;
        arst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, resp_valid, resp_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, resp_valid, resp_err});
        end
        n_checks++;
        if ({resp_rdata, resp_code} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_resp: got rdata=%h code=%b expected 0", resp_rdata, resp_code);
        end
        n_checks++;
        if ({m_axi.awaddr, m_axi.wdata, m_axi.wstrb, m_axi.araddr, m_axi.awprot, m_axi.arprot} !== 106'h0) begin
            n_fail++;
            $display("FAIL reset_payload: got awaddr=%h wdata=%h wstrb=%h araddr=%h expected 0", m_axi.awaddr, m_axi.wdata, m_axi.wstrb, m_axi.araddr);
        end
        arst = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_zero_wait_write;
        int base_aw = aw_tot, base_w = w_tot;
        aw_dly = 0; w_dly = 0; b_dly = 0; bresp_val = 2'b00;
        req_write = 1'b1; req_addr = 32'h0000_0004; req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF; req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        n_checks++;
        if ({m_axi.awvalid, m_axi.wvalid, req_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL zw_c1_valids: got aw/w/ready=%b expected 110", {m_axi.awvalid, m_axi.wvalid, req_ready});
        end
        n_checks++;
        if ({m_axi.awaddr, m_axi.wdata, m_axi.wstrb} !== {32'h0000_0004, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL zw_payload: got %h %h %h expected 00000004 deadbeef f", m_axi.awaddr, m_axi.wdata, m_axi.wstrb);
        end
        @(negedge aclk);
        n_checks++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, resp_valid} !== 4'b0010) begin
            n_fail++;
            $display("FAIL zw_c2: got aw/w/bready/resp=%b expected 0010", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, resp_valid});
        end
        @(negedge aclk);
        n_checks++;
        if ({resp_valid, resp_err, resp_code, m_axi.bready} !== 5'b10000) begin
            n_fail++;
            $display("FAIL zw_c3_resp: got valid/err/code/bready=%b expected 10000", {resp_valid, resp_err, resp_code, m_axi.bready});
        end
        n_checks++;
        if (resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL zw_rdata: got %h expected 0", resp_rdata);
        end
        @(negedge aclk);
        n_checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL zw_c4: got resp/ready=%b expected 01", {resp_valid, req_ready});
        end
        n_checks++;
        if (aw_tot - base_aw !== 1 || w_tot - base_w !== 1) begin
            n_fail++;
            $display("FAIL zw_beats: got aw=%0d w=%0d expected 1 1", aw_tot - base_aw, w_tot - base_w);
        end
    endtask

    task automatic test_skewed_write;
        int base_aw = aw_tot, base_w = w_tot;
        logic [3:0] exp [7];
        exp = '{4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0001, 4'b0000};
        aw_dly = 3; w_dly = 0; b_dly = 0; bresp_val = 2'b11;
        req_write = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hA5A5_0F0F; req_wstrb = 4'b0101; req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, resp_valid} !== exp[i]) begin
                n_fail++;
                $display("FAIL skew_c%0d: got aw/w/bready/resp=%b expected %b", i + 1, {m_axi.awvalid, m_axi.wvalid, m_axi.bready, resp_valid}, exp[i]);
            end
            if (i == 3) begin
                n_checks++;
                if (m_axi.awaddr !== 32'h0000_0010) begin
                    n_fail++;
                    $display("FAIL skew_awaddr_hold: got %h expected 00000010", m_axi.awaddr);
                end
            end
            if (i == 5) begin
                n_checks++;
                if ({resp_err, resp_code} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL skew_resp: got err/code=%b expected 111", {resp_err, resp_code});
                end
            end
            @(negedge aclk);
        end
        n_checks++;
        if (aw_tot - base_aw !== 1 || w_tot - base_w !== 1 || last_wstrb !== 4'b0101) begin
            n_fail++;
            $display("FAIL skew_beats: got aw=%0d w=%0d wstrb=%b expected 1 1 0101", aw_tot - base_aw, w_tot - base_w, last_wstrb);
        end
        aw_dly = 0;
    endtask

    task automatic test_read_error;
        logic [2:0] exp [6];
        exp = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
        ar_dly = 2; r_dly = 0; rdata_val = 32'h1234_5678; rresp_val = 2'b10;
        req_write = 1'b0; req_addr = 32'h0000_0100; req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        n_checks++;
        if (m_axi.araddr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL rd_araddr: got %h expected 00000100", m_axi.araddr);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({m_axi.arvalid, m_axi.rready, resp_valid} !== exp[i]) begin
                n_fail++;
                $display("FAIL rd_c%0d: got arvalid/rready/resp=%b expected %b", i + 1, {m_axi.arvalid, m_axi.rready, resp_valid}, exp[i]);
            end
            if (i == 4) begin
                n_checks++;
                if ({resp_rdata, resp_code, resp_err} !== {32'h1234_5678, 2'b10, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rd_resp: got rdata=%h code=%b err=%b expected 12345678 10 1", resp_rdata, resp_code, resp_err);
                end
            end
            @(negedge aclk);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ready_after: got %b expected 1", req_ready);
        end
        ar_dly = 0; rresp_val = 2'b00;
    endtask

    task automatic test_back_to_back;
        int base_ar = ar_tot, base_resp = resp_tot, t;
        logic ok;
        aw_dly = 0; w_dly = 0; ar_dly = 0; r_dly = 0; rdata_val = 32'hCAFE_0001; rresp_val = 2'b00;
        req_write = 1'b0; req_addr = 32'h0000_0200; req_valid = 1'b1;
        @(negedge aclk);
        req_addr = 32'h0000_0300;
        n_checks++;
        if ({req_ready, m_axi.arvalid, m_axi.araddr} !== {1'b0, 1'b1, 32'h0000_0200}) begin
            n_fail++;
            $display("FAIL b2b_busy: got ready=%b arvalid=%b araddr=%h expected 0 1 00000200", req_ready, m_axi.arvalid, m_axi.araddr);
        end
        t = 1;
        while (!req_ready && t < 20) begin
            @(negedge aclk);
            t++;
        end
        n_checks++;
        if (t !== 4) begin
            n_fail++;
            $display("FAIL b2b_ready_cycle: got C%0d expected C4", t);
        end
        @(negedge aclk);
        req_valid = 1'b0;
        wait_resp(ok);
        n_checks++;
        if ({ok, resp_rdata} !== {1'b1, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL b2b_second_resp: got seen=%b rdata=%h expected 1 cafe0001", ok, resp_rdata);
        end
        @(negedge aclk);
        n_checks++;
        if (ar_tot - base_ar !== 2 || resp_tot - base_resp !== 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got ar=%0d resp=%0d expected 2 2", ar_tot - base_ar, resp_tot - base_resp);
        end
        n_checks++;
        if ({ar_log[4'(base_ar)], ar_log[4'(base_ar + 1)]} !== {32'h0000_0200, 32'h0000_0300}) begin
            n_fail++;
            $display("FAIL b2b_addrs: got %h %h expected 00000200 00000300", ar_log[4'(base_ar)], ar_log[4'(base_ar + 1)]);
        end
    endtask

    task automatic test_random;
        int base_aw = aw_tot, base_ar = ar_tot, base_resp = resp_tot, base_viol = viol;
        int reqs = 0, resps = 0, bad = 0, nwr = 0, nrd = 0;
        logic ok, wr;
        logic [31:0] a, d, rd;
        logic [3:0]  s;
        logic [1:0]  c;
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            rd = $urandom;
            s  = 4'($urandom_range(0, 15));
            c  = 2'($urandom_range(0, 3));
            repeat (int'($urandom_range(0, 2))) @(negedge aclk);
            wait_ready(ok);
            if (!ok) begin
                bad++;
                break;
            end
            if (wr) bresp_val = c;
            else begin
                rresp_val = c;
                rdata_val = rd;
            end
            req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
            @(negedge aclk);
            req_valid = 1'b0;
            reqs++;
            if (wr) nwr++;
            else nrd++;
            wait_resp(ok);
            if (!ok) begin
                bad++;
                break;
            end
            resps++;
            if (wr ? ({last_awaddr, last_wdata, last_wstrb, resp_rdata} !== {a, d, s, 32'h0})
                   : ({last_araddr, resp_rdata} !== {a, rd}))
                bad++;
            if ({resp_code, resp_err} !== {c, c != 2'b00}) bad++;
        end
        @(negedge aclk);
        rand_mode = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_payload: got %0d bad transactions expected 0", bad);
        end
        n_checks++;
        if (resps !== reqs || resp_tot - base_resp !== reqs) begin
            n_fail++;
            $display("FAIL rand_resp_count: got %0d/%0d responses expected %0d", resps, resp_tot - base_resp, reqs);
        end
        n_checks++;
        if (aw_tot - base_aw !== nwr || ar_tot - base_ar !== nrd) begin
            n_fail++;
            $display("FAIL rand_beats: got aw=%0d ar=%0d expected %0d %0d", aw_tot - base_aw, ar_tot - base_ar, nwr, nrd);
        end
        n_checks++;
        if (viol - base_viol !== 0) begin
            n_fail++;
            $display("FAIL rand_stability: got %0d violations expected 0", viol - base_viol);
        end
    endtask

    task automatic test_reset_mid_write;
        int base_aw = aw_tot, base_resp = resp_tot, seen_resp = 0;
        logic ok;
        aw_dly = 100; w_dly = 100; bresp_val = 2'b00;
        req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF; req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        repeat (2) @(negedge aclk);
        n_checks++;
        if ({m_axi.awvalid, m_axi.wvalid} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_waiting: got aw/w=%b expected 11", {m_axi.awvalid, m_axi.wvalid});
        end
        #2 arst = 1'b1;
        #1;
        n_checks++;
        if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, resp_valid, req_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL mid_async: got aw/w/bready/resp/ready=%b expected 00001", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, resp_valid, req_ready});
        end
        @(negedge aclk);
        arst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) seen_resp++;
            @(negedge aclk);
        end
        n_checks++;
        if (seen_resp !== 0 || resp_tot - base_resp !== 0 || aw_tot - base_aw !== 0) begin
            n_fail++;
            $display("FAIL mid_no_resp: got resp=%0d aw=%0d expected 0 0", resp_tot - base_resp, aw_tot - base_aw);
        end
        aw_dly = 0; w_dly = 0;
        req_write = 1'b1; req_addr = 32'h0000_0044; req_wdata = 32'h0000_0001; req_wstrb = 4'h1; req_valid = 1'b1;
        @(negedge aclk);
        req_valid = 1'b0;
        wait_resp(ok);
        n_checks++;
        if ({ok, resp_code, last_awaddr} !== {1'b1, 2'b00, 32'h0000_0044}) begin
            n_fail++;
            $display("FAIL mid_recover: got seen=%b code=%b awaddr=%h expected 1 00 00000044", ok, resp_code, last_awaddr);
        end
        @(negedge aclk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_zero_wait_write;
        test_skewed_write;
        test_read_error;
        test_back_to_back;
        test_random;
        test_reset_mid_write;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
